btn_event: RTL and testbench
============================

# btn_event

Button event generator sitting directly downstream of the per-key debouncers on the Terasic DE1 demo: it takes the debounced, active-high button levels and turns them into a stream of discrete events (press, release, long-press, auto-repeat). It buffers these events in a small FIFO behind a valid/ready handshake. The soc consumes the stream through a PIO or a custom slave, and reset logic consumes the registered levels.

## Interface
- BN, 4, number of buttons (1..16)
- LONG, 24000000, cycles a button must stay held after PRESS before LONG is emitted (1 s at 24 MHz); ≥2
- RPT, 4800000, cycles between REPEAT events while held after LONG (200 ms at 24 MHz); ≥2
- FD, 4, event FIFO depth; power of 2, ≥2

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- d_i  in  BN  debounced button levels, 1 = pressed
- lvl  out  BN  registered copy of d_i
- evt_vld  out  1  FIFO head valid
- evt_rdy  in  1  consumer ready
- evt_btn  out  BW  button index of head event; BW = max(1, clog2(BN))
- evt_typ  out  2  head event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
- ovf  out  1  sticky event-loss flag

## Operation
- Reset values: lvl=0, evt_vld=0, evt_btn=0, evt_typ=0, ovf=0. All FSMs are IDLE, all pending slots are empty, the FIFO is empty, and all counters are 0.
- Input stage: lvl <= d_i on every edge. The FSMs act on lvl only, never on d_i directly.
- Each button has an FSM with states IDLE, PRESS and HOLD, plus a counter of width clog2(max(LONG,RPT)).
  - IDLE with lvl=1: go to PRESS, cnt=0, generate PRESS.
  - PRESS with lvl=0: go to IDLE, generate RELEASE.
  - PRESS with cnt==LONG-1: go to HOLD, cnt=0, generate LONG. Otherwise cnt++.
  - HOLD with lvl=0: go to IDLE, generate RELEASE.
  - HOLD with cnt==RPT-1: cnt=0, generate REPEAT. Otherwise cnt++.
  - lvl=0 has priority over counter expiry in the same cycle.
- Pending slots: each button has a 1-entry slot holding its event type.
  - A generated event loads the slot if the slot is empty, or if the slot is being drained in the same cycle.
  - Otherwise the event is dropped and ovf is set to 1. ovf is cleared only by rst.
- Arbiter: each cycle, if the FIFO will accept a write, the lowest-index non-empty slot is moved into the FIFO as {index, type}.
  - The FIFO accepts a write when it is not full, or when it is full and a pop occurs in the same cycle.
  - At most one slot is moved per cycle.
- FIFO is first-word-fall-through:
  - evt_vld = not empty; evt_btn and evt_typ show the head entry.
  - A pop happens when evt_vld & evt_rdy. Push and pop may occur in the same cycle.
  - Pointer width is clog2(FD)+1, using the wrap bit to distinguish full from empty.
- Per-button event order is preserved end to end. Across buttons, order is by generation cycle, with ties broken by lower index first.

## Timing
- d_i changes before edge E:
  - lvl updates at E.
  - FSM transitions and the slot loads at E+1.
  - FIFO write at E+2, so evt_vld=1 after E+2 if the FIFO was empty and not blocked.
- LONG loads its slot LONG cycles after the PRESS slot load. Each REPEAT follows RPT cycles after the previous LONG/REPEAT.
- Bursts: N simultaneous events drain to the FIFO on N consecutive cycles.
- Outputs are registered, with no combinational path from evt_rdy to evt_vld.
- rst asserted mid-operation clears everything immediately, including queued events.
  - After release, a button still held sees a lvl 0→1 transition and emits a fresh PRESS.

## Test plan
Use LONG=10, RPT=4, FD=4, BN=4.

- **Tap:** d_i[1]=1 for 3 cycles, evt_rdy=1 → events (1,PRESS) then (1,RELEASE), no LONG. First evt_vld appears after edge E+2.
- **Hold:** d_i[0]=1 for exactly 25 cycles → PRESS at E+1 load, LONG at E+11, REPEAT at E+15, E+19 and E+23, RELEASE at E+26. Six events total, ovf=0.
- **Simultaneous:** d_i 0000→1111 in one cycle, evt_rdy=1 → PRESS for buttons 0, 1, 2, 3 on four consecutive cycles.
- **Backpressure/overflow:** evt_rdy=0; toggle d_i[0] to give P,R,P,R,P,R with 3-cycle spacing.
  - The FIFO holds P,R,P,R; the 5th event (P) waits in the slot; the 6th (R) is dropped and ovf=1.
  - Then evt_rdy=1 → exactly 5 events drain in order, and ovf stays 1.
- **Same-cycle push/pop when full:** FIFO full with evt_rdy=1 held → one pop and one push per cycle, no loss, ovf=0.
- **Reset mid-hold:** button 2 in HOLD with 2 events queued; pulse rst → evt_vld=0, lvl=0 and ovf=0 immediately. With d_i[2] still 1, a new (2,PRESS) appears 3 edges after rst deasserts.

Source files
------------

// File: rtl/btn_event_if.sv
`default_nettype none
// ---------------------------------------------------------------
// btn_event_if : valid/ready event stream {button index, event type}
// rev 1.0
// ---------------------------------------------------------------
interface btn_event_if #(
  parameter int BN = 4
);
  localparam int BW = (BN > 1) ? $clog2(BN) : 1;

  logic          evt_vld;
  logic          evt_rdy;
  logic [BW-1:0] evt_btn;
  logic [1:0]    evt_typ;

  modport master (output evt_vld, output evt_btn, output evt_typ, input evt_rdy);
  modport slave  (input evt_vld, input evt_btn, input evt_typ, output evt_rdy);
endinterface
`default_nettype wire

// File: rtl/btn_event.sv
`default_nettype none
// ---------------------------------------------------------------
// btn_event : debounced buttons -> press/release/long/repeat event FIFO
// rev 1.0
// ---------------------------------------------------------------
module btn_event #(
  parameter int BN   = 4,
  parameter int LONG = 24000000,
  parameter int RPT  = 4800000,
  parameter int FD   = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic [BN-1:0] d_i,
  output logic      [BN-1:0] lvl,
  btn_event_if.master        evt,
  output logic               ovf
);
  localparam int BW = (BN > 1) ? $clog2(BN) : 1;
  localparam int CW = $clog2((LONG > RPT) ? LONG : RPT);
  localparam int AW = $clog2(FD);
  localparam int EW = BW + 2;

  localparam logic [1:0]    C_EV_PRESS   = 2'd0;
  localparam logic [1:0]    C_EV_RELEASE = 2'd1;
  localparam logic [1:0]    C_EV_LONG    = 2'd2;
  localparam logic [1:0]    C_EV_REPEAT  = 2'd3;
  localparam logic [CW-1:0] C_LONG_M1    = CW'(LONG - 1);
  localparam logic [CW-1:0] C_RPT_M1     = CW'(RPT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRESS = 2'd1, S_HOLD = 2'd2} state_t;

  logic [BN-1:0]       w_slot_v;
  logic [BN-1:0][1:0]  w_slot_t;
  logic [BN-1:0]       w_grant;
  logic [BN-1:0]       w_drop;
  logic                w_found;
  logic [EW-1:0]       w_wdata;
  logic                w_empty, w_full, w_pop, w_wr_ok, w_push;
  logic [EW-1:0]       r_mem [FD];
  logic [AW:0]         r_wp, r_rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl <= '0;
    else     lvl <= d_i;
  end

  generate
    for (genvar b = 0; b < BN; b++) begin : g_btn
      state_t        r_st;
      logic [CW-1:0] r_cnt;
      logic          r_sv;
      logic [1:0]    r_stp;
      logic          w_g;
      logic [1:0]    w_t;

      always_comb begin
        w_g = 1'b0;
        w_t = C_EV_PRESS;
        case (r_st)
          S_IDLE:  w_g = lvl[b];
          S_PRESS: begin
            if (!lvl[b]) begin
              w_g = 1'b1;
              w_t = C_EV_RELEASE;
            end else if (r_cnt == C_LONG_M1) begin
              w_g = 1'b1;
              w_t = C_EV_LONG;
            end
          end
          S_HOLD: begin
            if (!lvl[b]) begin
              w_g = 1'b1;
              w_t = C_EV_RELEASE;
            end else if (r_cnt == C_RPT_M1) begin
              w_g = 1'b1;
              w_t = C_EV_REPEAT;
            end
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_st  <= S_IDLE;
          r_cnt <= '0;
        end else begin
          case (r_st)
            S_IDLE: if (lvl[b]) begin
              r_st  <= S_PRESS;
              r_cnt <= '0;
            end
            S_PRESS: begin
              if (!lvl[b]) r_st <= S_IDLE;
              else if (r_cnt == C_LONG_M1) begin
                r_st  <= S_HOLD;
                r_cnt <= '0;
              end else r_cnt <= r_cnt + 1'b1;
            end
            S_HOLD: begin
              if (!lvl[b]) r_st <= S_IDLE;
              else if (r_cnt == C_RPT_M1) r_cnt <= '0;
              else r_cnt <= r_cnt + 1'b1;
            end
            default: r_st <= S_IDLE;
          endcase
        end
      end

      // A slot being drained this cycle can accept a new event in the same edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sv  <= 1'b0;
          r_stp <= C_EV_PRESS;
        end else if (w_g && (!r_sv || w_grant[b])) begin
          r_sv  <= 1'b1;
          r_stp <= w_t;
        end else if (w_grant[b]) begin
          r_sv  <= 1'b0;
        end
      end

      assign w_slot_v[b] = r_sv;
      assign w_slot_t[b] = r_stp;
      assign w_drop[b]   = w_g & r_sv & ~w_grant[b];
    end
  endgenerate

  always_comb begin
    w_grant = '0;
    w_wdata = '0;
    w_found = 1'b0;
    if (w_wr_ok) begin
      for (int i = 0; i < BN; i++) begin
        if (w_slot_v[i] && !w_found) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_wdata    = {BW'(i), w_slot_t[i]};
        end
      end
    end
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && evt.evt_rdy;
  assign w_wr_ok = !w_full || w_pop;
  assign w_push  = |w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < FD; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= w_wdata;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (|w_drop) ovf <= 1'b1;
    end
  end

  assign evt.evt_vld                 = !w_empty;
  assign {evt.evt_btn, evt.evt_typ}  = r_mem[r_rp[AW-1:0]];
endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_btn_event : directed + random stimulus against an event-rule model
// rev 1.0
// ---------------------------------------------------------------
module tb_btn_event;
  localparam int BN = 4, LONG = 10, RPT = 4, FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BN-1:0] d_i = '0;
  logic [BN-1:0] lvl;
  logic          ovf;

  btn_event_if #(.BN(BN)) evt_bus ();

  btn_event #(.BN(BN), .LONG(LONG), .RPT(RPT), .FD(FD)) dut (
    .clk (clk),
    .rst (rst),
    .d_i (d_i),
    .lvl (lvl),
    .evt (evt_bus),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: press age in cycles, one pending entry per button, FIFO as queues.
  bit [BN-1:0] m_lvl;
  bit          m_on  [BN];
  int          m_age [BN];
  bit          m_sv  [BN];
  int          m_st  [BN];
  bit          m_ovf;
  int          q_btn [$];
  int          q_typ [$];
  int          got   [$];

  function automatic int ev(input int b, input int t);
    return b * 4 + t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_lvl = '0;
    m_ovf = 1'b0;
    for (int b = 0; b < BN; b++) begin
      m_on[b] = 1'b0; m_age[b] = 0; m_sv[b] = 1'b0; m_st[b] = 0;
    end
    q_btn.delete();
    q_typ.delete();
  endtask

  task automatic step();
    bit pop, wr_ok, gen;
    int gb, t, eb, et;
    if (!rst && evt_bus.evt_vld && evt_bus.evt_rdy)
      got.push_back(ev(int'(evt_bus.evt_btn), int'(evt_bus.evt_typ)));
    @(posedge clk);
    if (rst) model_clear();
    else begin
      pop   = (q_btn.size() > 0) && evt_bus.evt_rdy;
      wr_ok = (q_btn.size() < FD) || pop;
      gb = -1; eb = 0; et = 0;
      if (wr_ok)
        for (int b = 0; b < BN; b++)
          if (m_sv[b] && gb < 0) gb = b;
      if (gb >= 0) begin
        eb = gb; et = m_st[gb]; m_sv[gb] = 1'b0;
      end
      for (int b = 0; b < BN; b++) begin
        gen = 1'b0; t = 0;
        if (!m_on[b]) begin
          if (m_lvl[b]) begin gen = 1'b1; t = 0; m_on[b] = 1'b1; m_age[b] = 0; end
        end else if (!m_lvl[b]) begin
          gen = 1'b1; t = 1; m_on[b] = 1'b0;
        end else begin
          m_age[b]++;
          if (m_age[b] == LONG) begin gen = 1'b1; t = 2; end
          else if (m_age[b] > LONG && (m_age[b] - LONG) % RPT == 0) begin gen = 1'b1; t = 3; end
        end
        if (gen) begin
          if (!m_sv[b]) begin m_sv[b] = 1'b1; m_st[b] = t; end
          else m_ovf = 1'b1;
        end
      end
      if (pop) begin void'(q_btn.pop_front()); void'(q_typ.pop_front()); end
      if (gb >= 0) begin q_btn.push_back(eb); q_typ.push_back(et); end
      m_lvl = d_i;
    end
    #1;
    chk("lvl", lvl, m_lvl);
    chk("evt_vld", evt_bus.evt_vld, q_btn.size() > 0);
    chk("ovf", ovf, m_ovf);
    if (q_btn.size() > 0) begin
      chk("evt_btn", evt_bus.evt_btn, q_btn[0]);
      chk("evt_typ", evt_bus.evt_typ, q_typ[0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_lvl", lvl, 0);
    chk("rst_vld", evt_bus.evt_vld, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_btn", evt_bus.evt_btn, 0);
    chk("rst_typ", evt_bus.evt_typ, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_h [6];
    model_clear();
    evt_bus.evt_rdy = 1'b0;
    repeat (2) step();
    chk("init_btn", evt_bus.evt_btn, 0);
    chk("init_typ", evt_bus.evt_typ, 0);
    rst = 1'b0;
    step();

    // Tap
    got.delete();
    evt_bus.evt_rdy = 1'b1;
    d_i = 4'b0010;
    step(); chk("tap_vld_e0", evt_bus.evt_vld, 0);
    step(); chk("tap_vld_e1", evt_bus.evt_vld, 0);
    step(); chk("tap_vld_e2", evt_bus.evt_vld, 1);
    chk("tap_head", ev(int'(evt_bus.evt_btn), int'(evt_bus.evt_typ)), ev(1, 0));
    d_i = '0;
    repeat (8) step();
    chk("tap_n", got.size(), 2);
    chk("tap_ev0", got[0], ev(1, 0));
    chk("tap_ev1", got[1], ev(1, 1));

    // Hold for 25 cycles
    got.delete();
    d_i = 4'b0001;
    repeat (25) step();
    d_i = '0;
    repeat (8) step();
    exp_h = '{0, 2, 3, 3, 3, 1};
    chk("hold_n", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("hold_ev", got[i], ev(0, exp_h[i]));
    chk("hold_ovf", ovf, 0);

    // Simultaneous presses
    got.delete();
    d_i = 4'b1111;
    repeat (6) step();
    d_i = '0;
    repeat (10) step();
    chk("sim_n", got.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk("sim_press", got[i], ev(i, 0));
      chk("sim_rel", got[i + 4], ev(i, 1));
    end

    // Backpressure and overflow
    got.delete();
    evt_bus.evt_rdy = 1'b0;
    repeat (3) begin
      d_i = 4'b0001; repeat (3) step();
      d_i = 4'b0000; repeat (3) step();
    end
    repeat (3) step();
    chk("bp_ovf", ovf, 1);
    chk("bp_vld", evt_bus.evt_vld, 1);
    evt_bus.evt_rdy = 1'b1;
    repeat (8) step();
    chk("bp_n", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_ev", got[i], ev(0, i % 2));
    chk("bp_ovf_sticky", ovf, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    got.delete();
    evt_bus.evt_rdy = 1'b0;
    d_i = 4'b1111;
    repeat (6) step();
    d_i = '0;
    repeat (2) step();
    evt_bus.evt_rdy = 1'b1;
    repeat (10) step();
    chk("full_n", got.size(), 8);
    for (int i = 0; i < 4; i++) chk("full_rel", got[i + 4], ev(i, 1));
    chk("full_ovf", ovf, 0);

    // Reset during hold
    got.delete();
    evt_bus.evt_rdy = 1'b0;
    d_i = 4'b0100;
    repeat (13) step();
    chk("rh_vld", evt_bus.evt_vld, 1);
    do_reset();
    step(); chk("rh_vld_e1", evt_bus.evt_vld, 0);
    step(); chk("rh_vld_e2", evt_bus.evt_vld, 0);
    step(); chk("rh_vld_e3", evt_bus.evt_vld, 1);
    chk("rh_head", ev(int'(evt_bus.evt_btn), int'(evt_bus.evt_typ)), ev(2, 0));
    d_i = '0;

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < BN; b++)
        if ($urandom_range(0, 19) == 0) d_i[b] = ~d_i[b];
      evt_bus.evt_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
